gcd_scheduler: RTL
==================

# gcd_scheduler

Shares one GCD core (control FSM plus subtract/compare datapath) between NREQ requesters. It arbitrates round-robin, latches the winner's operands, and sequences the core through clear, go and done. It returns the result to the winner with a one-cycle grant pulse. It sits between the requester fabric and the single GCD core instance.

## Interface
- NREQ, 4: number of requesters, 2..8
- WIDTH, 8: operand/result width
- TMO, 2*2**WIDTH+8: core watchdog limit, in cycles
- clk  in  1  clock, all logic on rising edge
- clr_n  in  1  synchronous active-low reset
- req  in  NREQ  request per requester; level, held until its gnt
- xin  in  NREQ*WIDTH  operand x, slice i for requester i
- yin  in  NREQ*WIDTH  operand y, slice i for requester i
- gnt  out  NREQ  one-hot completion pulse, 1 cycle
- vld  out  1  result valid, coincident with gnt
- gcd_out  out  WIDTH  result, valid when vld=1
- err  out  1  watchdog expiry flag, coincident with vld
- core_clr  out  1  holds core in its start state
- core_go  out  1  start request to core
- core_x  out  WIDTH  operand x to core
- core_y  out  WIDTH  operand y to core
- core_done  in  1  core done (gcd load), absorbing until core_clr
- core_gcd  in  WIDTH  core result

## Operation
- States: IDLE, LOAD, RUN, RESP.
- IDLE
  - core_clr=1.
  - If any req, pick winner = first set bit at or after ptr, wrapping at NREQ-1 -> 0.
  - Latch the winner's index, x and y; go to LOAD.
- LOAD
  - core_clr=1; core_x/core_y driven from latched registers.
  - Zero bypass: x==0 gives result y; y==0 gives result x; both 0 gives result 0. Each goes straight to RESP without running the core, because subtraction Euclid never terminates on zero.
  - Otherwise go to RUN and clear the watchdog.
- RUN
  - core_clr=0, core_go=1; core_x/core_y held stable.
  - On core_done=1: latch core_gcd and go to RESP.
  - On watchdog reaching TMO: result 0, err=1, go to RESP.
- RESP
  - If req[idx] is still 1: gnt[idx]=1, vld=1, gcd_out=result, err as latched.
  - If req[idx] has dropped: no pulse; the result is discarded.
  - In both cases ptr <= idx+1 mod NREQ, then return to IDLE.
- Operands are sampled only in IDLE. Requester changes after that point are ignored.
- A request arriving during service waits. Simultaneous requests are resolved by ptr only.
- Reset values: state IDLE, ptr 0, gnt 0, vld 0, err 0, gcd_out 0, core_go 0, core_clr 1, core_x 0, core_y 0.
- Reset asserted mid-RUN aborts the job: no gnt, core_clr=1 on the next cycle.

## Timing
- Cycle 0: req seen in IDLE. Cycle 1: LOAD. Cycle 2: RUN (or RESP on bypass). RESP follows the cycle in which core_done is sampled high.
- Bypass latency: req to vld is 2 cycles.
- Back-to-back service: next winner enters LOAD 2 cycles after the previous RESP.
- core_go stays high for all of RUN.
- core_clr is 1 in IDLE, LOAD and RESP, which guarantees the core returns to its start state between jobs.
- Watchdog counts RUN cycles at WIDTH+2 bits and saturates.
- All outputs are registered except core_x and core_y, which come straight from the operand registers.

## Structure
- Package gcd_pkg holds the state encoding (2-bit), the default WIDTH, and a helper function for the TMO default.
- Sub-module rr_pick: combinational round-robin priority encoder. Inputs req and ptr; outputs idx and any.
- The top level holds the FSM, the operand/result registers and the watchdog.

## Test plan
- Single request: req[1]=1, x=48, y=18 -> gnt=4'b0010, vld=1, gcd_out=6, err=0.
- Zero bypass: req[0] with x=0, y=35 -> gcd_out=35 exactly 2 cycles after req; core_go never rises.
- Fairness and wrap: req=4'b1111 held with ptr=3 -> grants in order 3, 0, 1, 2; each gnt is a single one-hot pulse.
- Withdraw: req[2] (x=21, y=14) dropped during RUN -> no gnt or vld; next pending requester served; ptr=3.
- Watchdog: core model never asserts core_done -> after TMO RUN cycles, vld=1, err=1, gcd_out=0.
- Reset mid-RUN: clr_n=0 for 1 cycle -> all outputs at reset values the next cycle; core_clr=1; a later request completes normally.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared types and defaults for the GCD core scheduler.
// Holds the FSM encoding, the default operand width and the watchdog default.
package gcd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_RESP = 2'd3
   } state_e;

   localparam int DEF_WIDTH = 8;

   // Subtraction Euclid needs at most about 2**width steps; the margin covers load and handoff.
   function automatic int tmo_default(input int width);
      return 2 * (2 ** width) + 8;
   endfunction

endpackage

// File: rtl/gcd_scheduler_if.sv
// Requester-side bus of the GCD scheduler: level requests with operands in, grant pulse with result out.
// Handshake: a requester holds req[i] and its operand slices until it sees gnt[i] for one cycle; vld, gcd_out and err are meaningful only in that same cycle.
interface gcd_scheduler_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8
);
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] xin;
   logic [NREQ*WIDTH-1:0] yin;
   logic [NREQ-1:0]       gnt;
   logic                  vld;
   logic [WIDTH-1:0]      gcd_out;
   logic                  err;

   modport master (output req, xin, yin, input gnt, vld, gcd_out, err);
   modport slave  (input req, xin, yin, output gnt, vld, gcd_out, err);
endinterface

// File: rtl/gcd_scheduler_rr_pick.sv
// Combinational round-robin priority encoder: first set request at or after ptr, wrapping.
// any is low when no request is set; idx is then 0.
module rr_pick #(
   parameter int NREQ = 4,
   parameter int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [IW-1:0]   idx,
   output logic            any
);

   // Scan from the farthest offset down so the nearest set bit is the last to assign.
   always_comb begin
      idx = '0;
      any = 1'b0;
      for (int off = NREQ - 1; off >= 0; off--) begin
         if (req[(int'(ptr) + off) % NREQ]) begin
            idx = IW'((int'(ptr) + off) % NREQ);
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/gcd_scheduler.sv
// Shares one GCD core between NREQ requesters: round-robin pick, operand latch, core sequencing,
// zero bypass, watchdog and a one-cycle grant pulse carrying the result.
module gcd_scheduler
   import gcd_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int WIDTH = DEF_WIDTH,
   parameter int TMO   = tmo_default(WIDTH)
) (
   input  logic                clk,
   input  logic                clr_n,
   gcd_scheduler_if.slave      bus,
   output logic                core_clr,
   output logic                core_go,
   output logic [WIDTH-1:0]    core_x,
   output logic [WIDTH-1:0]    core_y,
   input  logic                core_done,
   input  logic [WIDTH-1:0]    core_gcd,
   output state_e              dbg_state
);

   localparam int IW  = $clog2(NREQ);
   localparam int WDW = WIDTH + 2;
   localparam logic [WDW-1:0] WD_LIM = WDW'(TMO - 1);

   state_e            state_q, state_d;
   logic [IW-1:0]     ptr_q, ptr_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [WIDTH-1:0]  x_q, x_d;
   logic [WIDTH-1:0]  y_q, y_d;
   logic [WDW-1:0]    wd_q, wd_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic              vld_q, vld_d;
   logic [WIDTH-1:0]  gcd_out_q, gcd_out_d;
   logic              err_q, err_d;
   logic              core_go_q, core_go_d;
   logic              core_clr_q, core_clr_d;

   logic [IW-1:0]     pick_idx;
   logic              pick_any;
   logic              resp_go;
   logic [WIDTH-1:0]  resp_val;
   logic              resp_err;

   rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
      .req (bus.req),
      .ptr (ptr_q),
      .idx (pick_idx),
      .any (pick_any)
   );

   // Response outputs are computed on entry to RESP so they are registered yet coincide with it.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      idx_d     = idx_q;
      x_d       = x_q;
      y_d       = y_q;
      wd_d      = wd_q;
      gnt_d     = '0;
      vld_d     = 1'b0;
      gcd_out_d = '0;
      err_d     = 1'b0;
      resp_go   = 1'b0;
      resp_val  = '0;
      resp_err  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               idx_d   = pick_idx;
               x_d     = bus.xin[pick_idx*WIDTH +: WIDTH];
               y_d     = bus.yin[pick_idx*WIDTH +: WIDTH];
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            wd_d = '0;
            if (x_q == '0 || y_q == '0) begin
               resp_go  = 1'b1;
               resp_val = (x_q == '0) ? y_q : x_q;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (wd_q != '1) wd_d = wd_q + WDW'(1);
            if (core_done) begin
               resp_go  = 1'b1;
               resp_val = core_gcd;
            end else if (wd_q >= WD_LIM) begin
               resp_go  = 1'b1;
               resp_err = 1'b1;
            end
         end
         ST_RESP: begin
            ptr_d   = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + IW'(1);
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (resp_go) begin
         state_d = ST_RESP;
         if (bus.req[idx_q]) begin
            gnt_d[idx_q] = 1'b1;
            vld_d        = 1'b1;
            gcd_out_d    = resp_val;
            err_d        = resp_err;
         end
      end

      core_clr_d = (state_d != ST_RUN);
      core_go_d  = (state_d == ST_RUN);
   end

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         state_q    <= ST_IDLE;
         ptr_q      <= '0;
         idx_q      <= '0;
         x_q        <= '0;
         y_q        <= '0;
         wd_q       <= '0;
         gnt_q      <= '0;
         vld_q      <= 1'b0;
         gcd_out_q  <= '0;
         err_q      <= 1'b0;
         core_go_q  <= 1'b0;
         core_clr_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         idx_q      <= idx_d;
         x_q        <= x_d;
         y_q        <= y_d;
         wd_q       <= wd_d;
         gnt_q      <= gnt_d;
         vld_q      <= vld_d;
         gcd_out_q  <= gcd_out_d;
         err_q      <= err_d;
         core_go_q  <= core_go_d;
         core_clr_q <= core_clr_d;
      end
   end

   assign bus.gnt     = gnt_q;
   assign bus.vld     = vld_q;
   assign bus.gcd_out = gcd_out_q;
   assign bus.err     = err_q;
   assign core_clr    = core_clr_q;
   assign core_go     = core_go_q;
   assign core_x      = x_q;
   assign core_y      = y_q;
   assign dbg_state   = state_q;

endmodule
